// File: rtl/div19_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : div19_iter_if
// Brief    : Operand/result handshake bundle for the div19_iter divider.
// Revision : 1.0 - initial release
// ============================================================================
interface div19_iter_if #(
  parameter int WIDTH = 19
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;
  logic [1:0]       sel;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy, sel
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy, sel
  );
endinterface
`default_nettype wire

// File: rtl/div19_iter.sv
`default_nettype none
// ============================================================================
// Module   : div19_iter
// Brief    : Radix-2 restoring unsigned divider, one quotient bit per cycle.
//            Optional macro DIV19_EARLY_EXIT_EN: skip iterations when A < B.
// Revision : 1.0 - initial release
// ============================================================================
module div19_iter #(
  parameter int WIDTH = 19,
  parameter int CNT_W = 5
) (
  input  wire logic   clk,
  input  wire logic   reset,
  div19_iter_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [1:0] c_SEL_HOLD  = 2'b00;
  localparam logic [1:0] c_SEL_SHIFT = 2'b01;
  localparam logic [1:0] c_SEL_TRIAL = 2'b10;
  localparam logic [1:0] c_SEL_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_early;
  logic [WIDTH+1:0] w_trial;
  logic             w_trial_neg;
  logic [1:0]       w_sel;
  logic [WIDTH:0]   w_rem_nxt;

  assign w_accept   = bus.in_valid && (r_state == c_ST_IDLE);
  assign w_zero_div = (bus.divisor == '0);

`ifdef DIV19_EARLY_EXIT_EN
  assign w_early = (bus.dividend < bus.divisor);
`else
  assign w_early = 1'b0;
`endif

  // Guard bit above the remainder register carries the sign of S_hi - B.
  assign w_trial     = {r_rem, r_quo[WIDTH-1]} - {2'b00, r_div};
  assign w_trial_neg = w_trial[WIDTH+1];

  always_comb begin
    w_sel = c_SEL_HOLD;
    case (r_state)
      c_ST_IDLE: if (bus.in_valid) w_sel = c_SEL_LOAD;
      c_ST_RUN:  w_sel = w_trial_neg ? c_SEL_SHIFT : c_SEL_TRIAL;
      default:   w_sel = c_SEL_HOLD;
    endcase
  end

  // The exported select code drives the partial-remainder mux directly.
  always_comb begin
    w_rem_nxt = r_rem;
    case (w_sel)
      c_SEL_SHIFT: w_rem_nxt = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
      c_SEL_TRIAL: w_rem_nxt = w_trial[WIDTH:0];
      c_SEL_LOAD:  w_rem_nxt = (w_zero_div || w_early) ? {1'b0, bus.dividend} : '0;
      default:     w_rem_nxt = r_rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_rem <= w_rem_nxt;
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_div <= bus.divisor;
            if (w_zero_div) begin
              r_quo   <= '1;
              r_dbz   <= 1'b1;
              r_cnt   <= '0;
              r_state <= c_ST_DONE;
            end else if (w_early) begin
              r_quo   <= '0;
              r_dbz   <= 1'b0;
              r_cnt   <= '0;
              r_state <= c_ST_DONE;
            end else begin
              r_quo   <= bus.dividend;
              r_dbz   <= 1'b0;
              r_cnt   <= c_CNT_LOAD;
              r_state <= c_ST_RUN;
            end
          end
        end
        c_ST_RUN: begin
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial_neg};
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) r_state <= c_ST_DONE;
        end
        c_ST_DONE: begin
          if (bus.out_ready) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == c_ST_IDLE);
  assign bus.out_valid   = (r_state == c_ST_DONE);
  assign bus.busy        = (r_state == c_ST_RUN);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem[WIDTH-1:0];
  assign bus.div_by_zero = r_dbz;
  assign bus.sel         = w_sel;

endmodule
`default_nettype wire

// File: tb/tb_div19_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div19_iter
// Brief    : Scoreboard bench for div19_iter (honours DIV19_EARLY_EXIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div19_iter;

  localparam int c_WIDTH = 19;

  typedef struct {
    logic [c_WIDTH-1:0] q;
    logic [c_WIDTH-1:0] r;
    logic               dbz;
    int                 lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  div19_iter_if #(.WIDTH(c_WIDTH)) bus();

  div19_iter #(.WIDTH(c_WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair through the accept edge and record the expectation.
  task automatic send(input logic [c_WIDTH-1:0] a, input logic [c_WIDTH-1:0] b);
    exp_t e;
    chk("in_ready_pre", 32'(bus.in_ready), 32'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    #1;
    chk("sel_accept", 32'(bus.sel), 32'd3);
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = c_WIDTH + 1;
`ifdef DIV19_EARLY_EXIT_EN
      if (a < b) e.lat = 1;
`endif
    end
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, then retire it.
  task automatic collect(input int hold, input bit disturb);
    exp_t e;
    int   lat;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e   = sb.pop_front();
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk("busy_run", 32'(bus.busy), 32'd1);
      if (lat <= c_WIDTH)
        chk("sel_iter", 32'(bus.sel), e.q[c_WIDTH-lat] ? 32'd2 : 32'd1);
      if (disturb) begin
        bus.in_valid = 1'($urandom);
        bus.dividend = 19'($urandom);
        bus.divisor  = 19'($urandom);
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(e.lat));
    chk("quotient", 32'(bus.quotient), 32'(e.q));
    chk("remainder", 32'(bus.remainder), 32'(e.r));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
    chk("sel_done", 32'(bus.sel), 32'd0);
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("busy_done", 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_q", 32'(bus.quotient), 32'(e.q));
      chk("hold_r", 32'(bus.remainder), 32'(e.r));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("in_ready_rise", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);

    // Abort a division in flight with an asynchronous reset.
    send(19'd100, 19'd7);
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_q", 32'(bus.quotient), 32'd0);
    chk("abort_r", 32'(bus.remainder), 32'd0);
    chk("abort_sel", 32'(bus.sel), 32'd0);
    void'(sb.pop_front());
    tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end

    send(19'd100, 19'd7);          collect(0, 1'b0);
    send(19'h7FFFF, 19'd1);        collect(0, 1'b0);
    send(19'h7FFFF, 19'h7FFFF);    collect(0, 1'b0);
    send(19'h12345, 19'd0);        collect(0, 1'b0);
    send(19'd9, 19'd3);            collect(0, 1'b0);
    send(19'd1000, 19'd33);        collect(6, 1'b0);

    // Inputs toggled during RUN must not reach the result or start a new op.
    send(19'h5A5A5, 19'd77);       collect(0, 1'b1);
    repeat (2) begin
      tick();
      chk("no_extra_busy", 32'(bus.busy), 32'd0);
      chk("no_extra_valid", 32'(bus.out_valid), 32'd0);
    end

    send(19'd5, 19'd9);            collect(0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [c_WIDTH-1:0] a;
      logic [c_WIDTH-1:0] b;
      a = 19'($urandom);
      if (i == 3) b = '0;
      else        b = 19'($urandom_range(1, (i % 2) ? 200 : 524287));
      send(a, b);
      collect(i % 3, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
